hand_tracker: RTL and testbench
===============================

HAND_TRACKER -- requirements
Module: hand_tracker

Interface
REQ-001 Parameter MAX_CARDS, default 5, is the maximum number of cards held per hand and SHALL be at least 2.
REQ-002 Parameter CARD_W, default 4, is the rank field width and SHALL be at least 4.
REQ-003 Parameter SUM_W, default 6, is the total width and SHALL be at least clog2(MAX_CARDS*10+11).
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous and active-high.
REQ-006 i_add_valid  input  1  new card offered this cycle.
REQ-007 i_new_card  input  CARD_W  card rank: 1 is ace, 2-10 pip, 11-13 face; any other value is invalid.
REQ-008 o_add_ready  output  1  hand accepts a card this cycle.
REQ-009 i_stand  input  1  player stands, sampled each cycle.
REQ-010 o_cards  output  MAX_CARDS*CARD_W  held ranks, slot 0 at the LSBs, unused slots 0.
REQ-011 o_num_cards  output  clog2(MAX_CARDS+1)  count of held cards.
REQ-012 o_total  output  SUM_W  best blackjack total.
REQ-013 o_soft  output  1  o_total counts one ace as 11.
REQ-014 o_state  output  3  encoding OPEN=0, STOOD=1, BUST=2, BLACKJACK=3, CHARLIE=4.
REQ-015 o_done  output  1  hand is in any state other than OPEN.
REQ-016 o_bad_card  output  1  one-cycle pulse, invalid rank was presented.

Function
REQ-017 o_add_ready SHALL be 1 exactly when the state is OPEN and o_num_cards is less than MAX_CARDS.
REQ-018 A card SHALL be accepted on a cycle when i_add_valid and o_add_ready are both 1.
REQ-019 An accepted valid card SHALL be stored in slot o_num_cards, and o_num_cards SHALL increment, with all outputs showing the new card one cycle after acceptance.
REQ-020 An accepted invalid rank SHALL be discarded with no change to cards, count or totals, and o_bad_card SHALL be 1 on the following cycle only.
REQ-021 The internal hard sum SHALL add 1 for an ace, the rank for 2-10, and 10 for ranks 11-13, with no overflow given REQ-003.
REQ-022 o_total SHALL equal the hard sum plus 10 when at least one ace is held and hard sum plus 10 is 21 or less, and SHALL equal the hard sum otherwise.
REQ-023 o_soft SHALL be 1 exactly when the +10 of REQ-022 is applied.
REQ-024 From OPEN, after each accepted card, the next state SHALL be chosen in this priority order:
- BUST, if the total exceeds 21;
- BLACKJACK, if the total is 21 with exactly 2 cards;
- the full-hand state of REQ-030/031, if the count reaches MAX_CARDS;
- STOOD, if i_stand is 1;
- OPEN otherwise.
REQ-025 From OPEN, with no card accepted, i_stand=1 SHALL move the state to STOOD on the next edge.
REQ-026 STOOD, BUST, BLACKJACK and CHARLIE SHALL be terminal until reset, and i_add_valid and i_stand SHALL be ignored in them.
REQ-027 A total of 21 with 3 or more cards SHALL NOT end the hand and SHALL leave the state OPEN.

Reset
REQ-028 While i_reset=1 at a clock edge, the block SHALL set state OPEN, o_cards=0, o_num_cards=0, o_total=0, o_soft=0, o_done=0 and o_bad_card=0, and SHALL drop any card presented that cycle.
REQ-029 Reset asserted mid-hand, in any state, SHALL fully clear the hand, and o_add_ready SHALL be 1 on the cycle after reset deasserts.

Configuration
REQ-030 With macro HAND_TRACKER_CHARLIE_EN defined, a hand reaching MAX_CARDS cards without bust or blackjack SHALL enter CHARLIE (five-card Charlie win).
REQ-031 Without HAND_TRACKER_CHARLIE_EN, that same condition SHALL enter STOOD, and CHARLIE SHALL be unreachable.

Verification
REQ-032 Reset, then add 1 and 13 -> o_total=21, o_soft=1, o_state=BLACKJACK, o_add_ready=0.
REQ-033 Add 10, 6, 9 -> o_total=25, o_state=BUST after the third card, with a further valid card not accepted.
REQ-034 Add 1, 5, then 10 -> total 16 soft, then 16 hard (o_soft=0), state OPEN.
REQ-035 With CHARLIE_EN defined, add 2, 3, 2, 3, 2 -> o_total=12, o_num_cards=5, o_state=CHARLIE; without the macro, o_state=STOOD.
REQ-036 Add rank 14 -> o_bad_card pulses for 1 cycle with count 0; then card 7 with i_stand in the same cycle -> count 1, total 7, STOOD.
REQ-037 Reset asserted during BUST -> all outputs 0, state OPEN, o_add_ready=1 on the next cycle.

Source files
------------

// File: rtl/hand_tracker.sv
// hand_tracker -- tracks one blackjack hand and classifies its outcome.
//
// Purpose:
//   Accepts cards one at a time, keeps the held ranks, the hard sum and an
//   ace flag, and reports the best blackjack total together with the hand
//   state (OPEN, STOOD, BUST, BLACKJACK, CHARLIE).
//
// Ports:
//   i_clk        single clock; all state updates on the rising edge
//   i_reset      synchronous active-high reset
//   i_add_valid  a card is offered this cycle
//   i_new_card   card rank (1 ace, 2-10 pip, 11-13 face; others invalid)
//   o_add_ready  hand accepts a card this cycle
//   i_stand      player stands (sampled every cycle)
//   o_cards      held ranks, slot 0 at the LSBs, unused slots 0
//   o_num_cards  number of held cards
//   o_total      best blackjack total
//   o_soft       o_total counts one ace as 11
//   o_state      OPEN=0, STOOD=1, BUST=2, BLACKJACK=3, CHARLIE=4
//   o_done       state is not OPEN
//   o_bad_card   one-cycle pulse after an invalid rank was accepted
//
// Build option:
//   HAND_TRACKER_CHARLIE_EN -- when defined, a full hand that is neither bust
//   nor blackjack ends in CHARLIE; otherwise it ends in STOOD.

module hand_tracker #(
  parameter int MAX_CARDS = 5,
  parameter int CARD_W    = 4,
  parameter int SUM_W     = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_add_valid,
  input  logic [CARD_W-1:0]             i_new_card,
  output logic                          o_add_ready,
  input  logic                          i_stand,
  output logic [MAX_CARDS*CARD_W-1:0]   o_cards,
  output logic [$clog2(MAX_CARDS+1)-1:0] o_num_cards,
  output logic [SUM_W-1:0]              o_total,
  output logic                          o_soft,
  output logic [2:0]                    o_state,
  output logic                          o_done,
  output logic                          o_bad_card
);

  localparam int NUM_W = $clog2(MAX_CARDS + 1);

  typedef enum logic [2:0] {
    S_OPEN      = 3'd0,
    S_STOOD     = 3'd1,
    S_BUST      = 3'd2,
    S_BLACKJACK = 3'd3,
    S_CHARLIE   = 3'd4
  } state_e;

`ifdef HAND_TRACKER_CHARLIE_EN
  localparam state_e FULL_STATE = S_CHARLIE;
`else
  localparam state_e FULL_STATE = S_STOOD;
`endif

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [SUM_W-1:0]  hard_q, hard_d;
  logic [SUM_W-1:0]  total_q, total_d;
  logic              ace_q, ace_d;
  logic              soft_q, soft_d;
  logic              bad_q, bad_d;

  logic              accept;
  logic              card_ok;
  logic              add_good;
  logic [SUM_W-1:0]  card_val;

  assign o_add_ready = (state_q == S_OPEN) && (num_q < NUM_W'(MAX_CARDS));
  assign accept      = i_add_valid && o_add_ready;
  assign card_ok     = (i_new_card >= CARD_W'(1)) && (i_new_card <= CARD_W'(13));
  assign add_good    = accept && card_ok;

  // Face cards count 10; aces count 1 here and the +10 is decided on the total.
  always_comb begin
    card_val = '0;
    if (i_new_card >= CARD_W'(11)) begin
      card_val = SUM_W'(10);
    end else begin
      card_val = SUM_W'(i_new_card);
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    hard_d  = hard_q;
    ace_d   = ace_q;
    bad_d   = accept && !card_ok;

    if (add_good) begin
      num_d  = num_q + NUM_W'(1);
      hard_d = hard_q + card_val;
      ace_d  = ace_q | (i_new_card == CARD_W'(1));
    end

    // Only one ace can ever be promoted to 11 without busting.
    soft_d  = ace_d && ((hard_d + SUM_W'(10)) <= SUM_W'(21));
    total_d = soft_d ? (hard_d + SUM_W'(10)) : hard_d;

    if (state_q == S_OPEN) begin
      if (add_good) begin
        if (total_d > SUM_W'(21)) begin
          state_d = S_BUST;
        end else if ((total_d == SUM_W'(21)) && (num_d == NUM_W'(2))) begin
          state_d = S_BLACKJACK;
        end else if (num_d == NUM_W'(MAX_CARDS)) begin
          state_d = FULL_STATE;
        end else if (i_stand) begin
          state_d = S_STOOD;
        end
      end else if (i_stand) begin
        state_d = S_STOOD;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_OPEN;
      num_q   <= '0;
      hard_q  <= '0;
      total_q <= '0;
      ace_q   <= 1'b0;
      soft_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      hard_q  <= hard_d;
      total_q <= total_d;
      ace_q   <= ace_d;
      soft_q  <= soft_d;
      bad_q   <= bad_d;
    end
  end

  // One register per slot; a slot loads when it is the next free one.
  for (genvar gi = 0; gi < MAX_CARDS; gi++) begin : g_slot
    logic [CARD_W-1:0] slot_q;
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        slot_q <= '0;
      end else if (add_good && (num_q == NUM_W'(gi))) begin
        slot_q <= i_new_card;
      end
    end
    assign o_cards[gi*CARD_W +: CARD_W] = slot_q;
  end

  assign o_num_cards = num_q;
  assign o_total     = total_q;
  assign o_soft      = soft_q;
  assign o_state     = state_q;
  assign o_done      = (state_q != S_OPEN);
  assign o_bad_card  = bad_q;

endmodule

// File: tb/tb_hand_tracker.sv
// Directed testbench for hand_tracker with default parameters.

module tb_hand_tracker;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_add_valid = 1'b0;
  logic [3:0]  i_new_card = 4'd0;
  logic        o_add_ready;
  logic        i_stand = 1'b0;
  logic [19:0] o_cards;
  logic [2:0]  o_num_cards;
  logic [5:0]  o_total;
  logic        o_soft;
  logic [2:0]  o_state;
  logic        o_done;
  logic        o_bad_card;

  int n_cmp = 0;
  int n_err = 0;

`ifdef HAND_TRACKER_CHARLIE_EN
  localparam logic [2:0] FULL_EXP = 3'd4;
`else
  localparam logic [2:0] FULL_EXP = 3'd1;
`endif

  hand_tracker dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_add_valid (i_add_valid),
    .i_new_card  (i_new_card),
    .o_add_ready (o_add_ready),
    .i_stand     (i_stand),
    .o_cards     (o_cards),
    .o_num_cards (o_num_cards),
    .o_total     (o_total),
    .o_soft      (o_soft),
    .o_state     (o_state),
    .o_done      (o_done),
    .o_bad_card  (o_bad_card)
  );

  always #5 i_clk = ~i_clk;

  // Offer one card for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic add_card(input logic [3:0] rank, input logic stand);
    i_add_valid = 1'b1;
    i_new_card  = rank;
    i_stand     = stand;
    @(posedge i_clk);
    #1;
    i_add_valid = 1'b0;
    i_new_card  = 4'd0;
    i_stand     = 1'b0;
    $display("add rank=%0d stand=%0d -> num=%0d total=%0d soft=%0d state=%0d rdy=%0d bad=%0d",
             rank, stand, o_num_cards, o_total, o_soft, o_state, o_add_ready, o_bad_card);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", o_state); end
    n_cmp++; if (o_cards !== 20'h0) begin n_err++; $display("FAIL rst_cards got %h want 0", o_cards); end
    n_cmp++; if (o_num_cards !== 3'd0) begin n_err++; $display("FAIL rst_num got %0d want 0", o_num_cards); end
    n_cmp++; if (o_total !== 6'd0) begin n_err++; $display("FAIL rst_total got %0d want 0", o_total); end
    n_cmp++; if ({o_soft, o_done, o_bad_card} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {o_soft, o_done, o_bad_card}); end
    n_cmp++; if (o_add_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0d want 1", o_add_ready); end
  endtask

  task automatic test_blackjack();
    do_reset();
    add_card(4'd1, 1'b0);
    add_card(4'd13, 1'b0);
    n_cmp++; if (o_total !== 6'd21) begin n_err++; $display("FAIL bj_total got %0d want 21", o_total); end
    n_cmp++; if (o_soft !== 1'b1) begin n_err++; $display("FAIL bj_soft got %0d want 1", o_soft); end
    n_cmp++; if (o_state !== 3'd3) begin n_err++; $display("FAIL bj_state got %0d want 3", o_state); end
    n_cmp++; if (o_add_ready !== 1'b0) begin n_err++; $display("FAIL bj_ready got %0d want 0", o_add_ready); end
    n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL bj_done got %0d want 1", o_done); end
    n_cmp++; if (o_cards !== 20'h000D1) begin n_err++; $display("FAIL bj_cards got %h want 000d1", o_cards); end
  endtask

  task automatic test_bust();
    do_reset();
    add_card(4'd10, 1'b0);
    add_card(4'd6, 1'b0);
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL bust_mid_state got %0d want 0", o_state); end
    add_card(4'd9, 1'b0);
    n_cmp++; if (o_total !== 6'd25) begin n_err++; $display("FAIL bust_total got %0d want 25", o_total); end
    n_cmp++; if (o_state !== 3'd2) begin n_err++; $display("FAIL bust_state got %0d want 2", o_state); end
    add_card(4'd2, 1'b1);
    n_cmp++; if (o_num_cards !== 3'd3) begin n_err++; $display("FAIL bust_noadd_num got %0d want 3", o_num_cards); end
    n_cmp++; if (o_total !== 6'd25) begin n_err++; $display("FAIL bust_noadd_total got %0d want 25", o_total); end
    n_cmp++; if (o_state !== 3'd2) begin n_err++; $display("FAIL bust_terminal got %0d want 2", o_state); end
  endtask

  task automatic test_soft_to_hard();
    do_reset();
    add_card(4'd1, 1'b0);
    add_card(4'd5, 1'b0);
    n_cmp++; if ({o_total, o_soft} !== {6'd16, 1'b1}) begin n_err++; $display("FAIL soft16 got total=%0d soft=%0d want 16/1", o_total, o_soft); end
    add_card(4'd10, 1'b0);
    n_cmp++; if ({o_total, o_soft} !== {6'd16, 1'b0}) begin n_err++; $display("FAIL hard16 got total=%0d soft=%0d want 16/0", o_total, o_soft); end
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL hard16_state got %0d want 0", o_state); end
    n_cmp++; if (o_num_cards !== 3'd3) begin n_err++; $display("FAIL hard16_num got %0d want 3", o_num_cards); end
  endtask

  task automatic test_three_card_21();
    do_reset();
    add_card(4'd7, 1'b0);
    add_card(4'd7, 1'b0);
    add_card(4'd7, 1'b0);
    n_cmp++; if (o_total !== 6'd21) begin n_err++; $display("FAIL t21_total got %0d want 21", o_total); end
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL t21_state got %0d want 0", o_state); end
    n_cmp++; if (o_add_ready !== 1'b1) begin n_err++; $display("FAIL t21_ready got %0d want 1", o_add_ready); end
  endtask

  task automatic test_full_hand();
    do_reset();
    add_card(4'd2, 1'b0);
    add_card(4'd3, 1'b0);
    add_card(4'd2, 1'b0);
    add_card(4'd3, 1'b0);
    add_card(4'd2, 1'b0);
    n_cmp++; if (o_total !== 6'd12) begin n_err++; $display("FAIL full_total got %0d want 12", o_total); end
    n_cmp++; if (o_num_cards !== 3'd5) begin n_err++; $display("FAIL full_num got %0d want 5", o_num_cards); end
    n_cmp++; if (o_state !== FULL_EXP) begin n_err++; $display("FAIL full_state got %0d want %0d", o_state, FULL_EXP); end
    n_cmp++; if (o_cards !== 20'h23232) begin n_err++; $display("FAIL full_cards got %h want 23232", o_cards); end
    n_cmp++; if (o_add_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0d want 0", o_add_ready); end
  endtask

  task automatic test_bad_card();
    do_reset();
    add_card(4'd14, 1'b0);
    n_cmp++; if (o_bad_card !== 1'b1) begin n_err++; $display("FAIL bad_pulse got %0d want 1", o_bad_card); end
    n_cmp++; if (o_num_cards !== 3'd0) begin n_err++; $display("FAIL bad_num got %0d want 0", o_num_cards); end
    n_cmp++; if (o_total !== 6'd0) begin n_err++; $display("FAIL bad_total got %0d want 0", o_total); end
    add_card(4'd7, 1'b1);
    n_cmp++; if (o_bad_card !== 1'b0) begin n_err++; $display("FAIL bad_clear got %0d want 0", o_bad_card); end
    n_cmp++; if ({o_num_cards, o_total} !== {3'd1, 6'd7}) begin n_err++; $display("FAIL stand7 got num=%0d total=%0d want 1/7", o_num_cards, o_total); end
    n_cmp++; if (o_state !== 3'd1) begin n_err++; $display("FAIL stand7_state got %0d want 1", o_state); end
    add_card(4'd4, 1'b0);
    n_cmp++; if (o_num_cards !== 3'd1) begin n_err++; $display("FAIL stood_noadd got %0d want 1", o_num_cards); end
    add_card(4'd0, 1'b0);
    n_cmp++; if (o_bad_card !== 1'b0) begin n_err++; $display("FAIL stood_nobad got %0d want 0", o_bad_card); end
  endtask

  task automatic test_reset_mid_hand();
    do_reset();
    add_card(4'd10, 1'b0);
    add_card(4'd10, 1'b0);
    add_card(4'd5, 1'b0);
    n_cmp++; if (o_state !== 3'd2) begin n_err++; $display("FAIL mid_bust got %0d want 2", o_state); end
    // A card offered together with reset must be dropped.
    i_reset     = 1'b1;
    i_add_valid = 1'b1;
    i_new_card  = 4'd5;
    @(posedge i_clk);
    #1;
    i_reset     = 1'b0;
    i_add_valid = 1'b0;
    i_new_card  = 4'd0;
    n_cmp++; if ({o_cards, o_num_cards, o_total} !== 29'd0) begin n_err++; $display("FAIL mid_clear got cards=%h num=%0d total=%0d want 0", o_cards, o_num_cards, o_total); end
    n_cmp++; if ({o_state, o_soft, o_done, o_bad_card} !== 6'd0) begin n_err++; $display("FAIL mid_flags got state=%0d soft=%0d done=%0d bad=%0d want 0", o_state, o_soft, o_done, o_bad_card); end
    @(posedge i_clk);
    #1;
    n_cmp++; if (o_add_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got %0d want 1", o_add_ready); end
    n_cmp++; if (o_num_cards !== 3'd0) begin n_err++; $display("FAIL mid_drop got %0d want 0", o_num_cards); end
  endtask

  task automatic test_stand_idle();
    do_reset();
    i_stand = 1'b1;
    @(posedge i_clk);
    #1;
    i_stand = 1'b0;
    n_cmp++; if ({o_state, o_done} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL idle_stand got state=%0d done=%0d want 1/1", o_state, o_done); end
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    test_reset();
    test_blackjack();
    test_bust();
    test_soft_to_hard();
    test_three_card_21();
    test_full_hand();
    test_bad_card();
    test_reset_mid_hand();
    test_stand_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
